// File: rtl/mem_stage.sv
// RV32I memory-access stage: EX/MEM pipeline register plus a word-organised data RAM
// with byte/half/word loads and stores and alignment detection.
module mem_stage #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallM,
    input  logic        FlushM,
    input  logic        memWrite_E,
    input  logic        memRead_E,
    input  logic        regWrite_E,
    input  logic [1:0]  write_back_E,
    input  logic [31:0] alu_rsl_E,
    input  logic [31:0] write_data_E,
    input  logic [31:0] pc4_E,
    input  logic [31:0] imm_extended_E,
    input  logic [4:0]  rd_E,
    input  logic [2:0]  mode_E,
    output logic        memWrite_M,
    output logic        memRead_M,
    output logic        regWrite_M,
    output logic [1:0]  write_back_M,
    output logic [31:0] alu_rsl_M,
    output logic [31:0] pc4_M,
    output logic [31:0] imm_extended_M,
    output logic [4:0]  rd_M,
    output logic [31:0] read_data_M,
    output logic        misaligned_M
);

    logic [31:0] write_data_M;
    logic [2:0]  mode_M;

    // rst_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n || FlushM) begin
            memWrite_M     <= 1'b0;
            memRead_M      <= 1'b0;
            regWrite_M     <= 1'b0;
            write_back_M   <= '0;
            alu_rsl_M      <= '0;
            write_data_M   <= '0;
            pc4_M          <= '0;
            imm_extended_M <= '0;
            rd_M           <= '0;
            mode_M         <= '0;
        end else if (!StallM) begin
            memWrite_M     <= memWrite_E;
            memRead_M      <= memRead_E;
            regWrite_M     <= regWrite_E;
            write_back_M   <= write_back_E;
            alu_rsl_M      <= alu_rsl_E;
            write_data_M   <= write_data_E;
            pc4_M          <= pc4_E;
            imm_extended_M <= imm_extended_E;
            rd_M           <= rd_E;
            mode_M         <= mode_E;
        end
    end

    logic [31:0]          ram [0:(2**ADDR_BITS)-1];
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           offset;
    logic                 violation;
    logic [3:0]           lanes;
    logic [31:0]          wdata;
    logic                 store_en;
    logic [31:0]          rword;
    logic [31:0]          shifted;
    logic [31:0]          load_val;

    assign word_idx = alu_rsl_M[ADDR_BITS+1:2];
    assign offset   = alu_rsl_M[1:0];

    always_comb begin
        violation = 1'b1;
        case (mode_M[1:0])
            2'b00:   violation = 1'b0;
            2'b01:   violation = offset[0];
            2'b10:   violation = |offset;
            default: violation = 1'b1;
        endcase
    end

    assign misaligned_M = (memRead_M | memWrite_M) & violation;

    always_comb begin
        lanes = '0;
        wdata = '0;
        case (mode_M[1:0])
            2'b00: begin
                lanes = 4'b0001 << offset;
                wdata = {4{write_data_M[7:0]}};
            end
            2'b01: begin
                lanes = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{write_data_M[15:0]}};
            end
            2'b10: begin
                lanes = 4'b1111;
                wdata = write_data_M;
            end
            default: begin
                lanes = '0;
                wdata = '0;
            end
        endcase
    end

    assign store_en = memWrite_M & ~misaligned_M & ~rst_n;

    // Contents are deliberately left out of reset so a pipeline reset keeps data.
    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lanes[i]) begin
                    ram[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rword   = ram[word_idx];
    assign shifted = rword >> {offset, 3'b000};

    always_comb begin
        load_val = '0;
        case (mode_M)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {24'h0, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_val = {16'h0, shifted[15:0]};
            3'b010,
            3'b110:  load_val = rword;
            default: load_val = '0;
        endcase
    end

    assign read_data_M = (memRead_M && !misaligned_M) ? load_val : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-addressed reference memory and stage model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_stage;

    localparam int unsigned AB = 10;
    localparam int unsigned NW = 1 << AB;

    logic        clk = 1'b0;
    logic        rst_n, StallM, FlushM;
    logic        memWrite_E, memRead_E, regWrite_E;
    logic [1:0]  write_back_E;
    logic [31:0] alu_rsl_E, write_data_E, pc4_E, imm_extended_E;
    logic [4:0]  rd_E;
    logic [2:0]  mode_E;
    logic        memWrite_M, memRead_M, regWrite_M;
    logic [1:0]  write_back_M;
    logic [31:0] alu_rsl_M, pc4_M, imm_extended_M;
    logic [4:0]  rd_M;
    logic [31:0] read_data_M;
    logic        misaligned_M;

    mem_stage #(.ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n), .StallM(StallM), .FlushM(FlushM),
        .memWrite_E(memWrite_E), .memRead_E(memRead_E), .regWrite_E(regWrite_E),
        .write_back_E(write_back_E), .alu_rsl_E(alu_rsl_E), .write_data_E(write_data_E),
        .pc4_E(pc4_E), .imm_extended_E(imm_extended_E), .rd_E(rd_E), .mode_E(mode_E),
        .memWrite_M(memWrite_M), .memRead_M(memRead_M), .regWrite_M(regWrite_M),
        .write_back_M(write_back_M), .alu_rsl_M(alu_rsl_M), .pc4_M(pc4_M),
        .imm_extended_M(imm_extended_M), .rd_M(rd_M), .read_data_M(read_data_M),
        .misaligned_M(misaligned_M)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        mw, mr, rw;
        bit [1:0]  wb;
        bit [31:0] alu, wd, pc4, imm;
        bit [4:0]  rd;
        bit [2:0]  mode;
    } stage_t;

    stage_t   s;
    bit       model_ok = 1'b0;
    bit [7:0] mb [NW*4];
    bit       mv [NW*4];
    int       pass_cnt = 0;
    int       total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit misal_f(input stage_t x);
        int unsigned sz;
        if (!(x.mr || x.mw)) return 1'b0;
        if (x.mode[1:0] == 2'd3) return 1'b1;
        sz = 1 << x.mode[1:0];
        return (x.alu % sz) != 0;
    endfunction

    function automatic int unsigned baddr(input stage_t x);
        return ((x.alu >> 2) % NW) * 4 + (x.alu % 4);
    endfunction

    // Returns 0 when a needed byte has never been written (value unknown).
    function automatic bit exp_read(input stage_t x, output logic [31:0] v);
        int unsigned sz, b;
        logic [31:0] raw;
        v = 32'h0;
        if (!x.mr || misal_f(x)) return 1'b1;
        sz  = 1 << x.mode[1:0];
        b   = baddr(x);
        raw = 32'h0;
        for (int unsigned i = 0; i < sz; i++) begin
            if (!mv[b+i]) return 1'b0;
            raw = raw | (32'(mb[b+i]) << (8*i));
        end
        if (sz == 1)      v = (!x.mode[2] && raw[7])  ? (raw | 32'hFFFF_FF00) : raw;
        else if (sz == 2) v = (!x.mode[2] && raw[15]) ? (raw | 32'hFFFF_0000) : raw;
        else              v = raw;
        return 1'b1;
    endfunction

    initial for (int i = 0; i < NW*4; i++) mv[i] = 1'b0;

    always @(posedge clk) begin
        if (model_ok && s.mw && !misal_f(s) && !rst_n) begin
            for (int unsigned i = 0; i < (1 << s.mode[1:0]); i++) begin
                mb[baddr(s)+i] <= s.wd[8*i +: 8];
                mv[baddr(s)+i] <= 1'b1;
            end
        end
        if (rst_n || FlushM) begin
            s <= '{default: '0};
            model_ok <= 1'b1;
        end else if (!StallM) begin
            s <= '{mw: memWrite_E, mr: memRead_E, rw: regWrite_E, wb: write_back_E,
                   alu: alu_rsl_E, wd: write_data_E, pc4: pc4_E, imm: imm_extended_E,
                   rd: rd_E, mode: mode_E};
        end
    end

    always @(negedge clk) begin
        logic [31:0] v;
        if (model_ok) begin
            chk("memWrite_M", 32'(memWrite_M), 32'(s.mw));
            chk("memRead_M", 32'(memRead_M), 32'(s.mr));
            chk("regWrite_M", 32'(regWrite_M), 32'(s.rw));
            chk("write_back_M", 32'(write_back_M), 32'(s.wb));
            chk("alu_rsl_M", alu_rsl_M, s.alu);
            chk("pc4_M", pc4_M, s.pc4);
            chk("imm_extended_M", imm_extended_M, s.imm);
            chk("rd_M", 32'(rd_M), 32'(s.rd));
            chk("misaligned_M", 32'(misaligned_M), 32'(misal_f(s)));
            if (exp_read(s, v)) chk("read_data_M", read_data_M, v);
        end
    end

    task automatic op(input bit mw, input bit mr, input bit rw, input logic [1:0] wb,
                      input logic [4:0] rd, input logic [2:0] mode, input logic [31:0] addr,
                      input logic [31:0] data, input bit stall = 0, input bit flush = 0,
                      input bit rst = 0);
        memWrite_E = mw; memRead_E = mr; regWrite_E = rw; write_back_E = wb;
        rd_E = rd; mode_E = mode; alu_rsl_E = addr; write_data_E = data;
        pc4_E = $urandom; imm_extended_E = $urandom;
        StallM = stall; FlushM = flush; rst_n = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] data);
        op(1, 0, 0, 2'b00, 5'd0, mode, addr, data);
    endtask

    task automatic ld(input logic [2:0] mode, input logic [31:0] addr);
        op(0, 1, 1, 2'b01, 5'd5, mode, addr, 32'h0);
    endtask

    task automatic nop();
        op(0, 0, 0, 2'b00, 5'd0, 3'd0, 32'h0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addr, data;
        logic [2:0]  mode;
        int unsigned r;

        // 1: reset and pass-through
        op(0, 0, 0, 2'b00, 5'd0, 3'd0, 32'h0, 32'h0, 0, 0, 1);
        op(1, 1, 1, 2'b11, 5'd9, 3'd2, 32'hFFFF, 32'h1, 0, 0, 1);
        chk("rst_alu", alu_rsl_M, 32'h0);
        chk("rst_rd", 32'(rd_M), 32'h0);
        chk("rst_ctrl", {29'h0, memWrite_M, memRead_M, regWrite_M}, 32'h0);
        chk("rst_read", read_data_M, 32'h0);
        op(0, 0, 1, 2'b00, 5'd7, 3'd0, 32'h1234, 32'h0);
        chk("pt_alu", alu_rsl_M, 32'h1234);
        chk("pt_rd", 32'(rd_M), 32'd7);
        chk("pt_rw", 32'(regWrite_M), 32'h1);

        // 2: word store/load and address wrap
        st(3'b010, 32'h10, 32'hDEADBEEF);
        ld(3'b010, 32'h10);
        chk("lw", read_data_M, 32'hDEADBEEF);
        ld(3'b010, 32'h10 + (32'd4 << AB));
        chk("lw_wrap", read_data_M, 32'hDEADBEEF);

        // 3: sub-word accesses
        st(3'b000, 32'h21, 32'h80);
        ld(3'b000, 32'h21);
        chk("lb", read_data_M, 32'hFFFFFF80);
        ld(3'b100, 32'h21);
        chk("lbu", read_data_M, 32'h00000080);
        st(3'b001, 32'h22, 32'h8001);
        ld(3'b001, 32'h22);
        chk("lh", read_data_M, 32'hFFFF8001);
        ld(3'b010, 32'h20);
        chk("lw_mixed", {8'h0, read_data_M[31:8]}, 32'h00800180);

        // 4: misaligned accesses
        ld(3'b010, 32'h13);
        chk("lw_mis_flag", 32'(misaligned_M), 32'h1);
        chk("lw_mis_data", read_data_M, 32'h0);
        st(3'b001, 32'h11, 32'hAAAA);
        chk("sh_mis_flag", 32'(misaligned_M), 32'h1);
        ld(3'b010, 32'h10);
        chk("sh_mis_nowrite", read_data_M, 32'hDEADBEEF);

        // 5: stall holds, flush overrides stall
        st(3'b010, 32'h30, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            op(0, 1, 1, 2'b01, 5'd3, 3'd2, 32'h99, 32'h0, 1);
            chk("stall_alu", alu_rsl_M, 32'h30);
            chk("stall_mw", 32'(memWrite_M), 32'h1);
        end
        op(0, 1, 1, 2'b01, 5'd3, 3'd2, 32'h99, 32'h0, 1, 1);
        chk("flush_ctrl", {30'h0, memWrite_M, regWrite_M}, 32'h0);
        ld(3'b010, 32'h30);
        chk("stall_store", read_data_M, 32'h12345678);

        // 6: reset blocks the store entering with it
        st(3'b010, 32'h40, 32'h55);
        nop();
        op(1, 0, 0, 2'b00, 5'd0, 3'd2, 32'h40, 32'h66, 0, 0, 1);
        nop();
        ld(3'b010, 32'h40);
        chk("rst_blocks_store", read_data_M, 32'h55);

        // randomized traffic over a small window with random upper address bits
        for (int n = 0; n < 1500; n++) begin
            r    = $urandom_range(0, 9);
            addr = $urandom;
            addr[AB+1:2] = AB'($urandom_range(0, 15));
            data = $urandom;
            if (r < 4) begin
                mode = 3'($urandom_range(0, 2));
                if ($urandom_range(0, 19) == 0) mode = 3'd3;
                op(1, 0, 0, 2'($urandom), 5'($urandom), mode, addr, data,
                   $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                   $urandom_range(0, 99) < 2);
            end else if (r < 8) begin
                case ($urandom_range(0, 5))
                    0: mode = 3'd0;
                    1: mode = 3'd1;
                    2: mode = 3'd2;
                    3: mode = 3'd4;
                    4: mode = 3'd5;
                    default: mode = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd7;
                endcase
                op(0, 1, 1, 2'($urandom), 5'($urandom), mode, addr, data,
                   $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                   $urandom_range(0, 99) < 2);
            end else begin
                op(0, 0, r[0], 2'($urandom), 5'($urandom), 3'($urandom), addr, data,
                   $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                   $urandom_range(0, 99) < 2);
            end
        end

        nop();
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the RV32I 5-stage pipeline. It sits directly downstream of the execute stage. It registers the EX outputs into the EX/MEM pipeline register and performs byte/half/word loads and stores on a local word-organised data RAM. It then presents the load result, the forwarding value and the write-back controls to the WB stage and to the hazard/forwarding unit.

Parameters:
ADDR_BITS, 10, word-index width; RAM holds 2^ADDR_BITS 32-bit words (4 KiB default)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-high reset (1 = reset); name kept for codebase consistency
StallM  in  1  hold EX/MEM register
FlushM  in  1  insert bubble into EX/MEM register
memWrite_E  in  1  store request from EX
memRead_E  in  1  load request from EX
regWrite_E  in  1  register-file write enable from EX
write_back_E  in  2  WB mux select (00 ALU, 01 load data, 10 pc+4, 11 imm)
alu_rsl_E  in  32  ALU result / effective address
write_data_E  in  32  forwarded rs2 value (store data)
pc4_E  in  32  pc+4
imm_extended_E  in  32  extended immediate
rd_E  in  5  destination register
mode_E  in  3  funct3 access mode
memWrite_M, memRead_M, regWrite_M  out  1 each  registered controls
write_back_M  out  2  registered WB select
alu_rsl_M  out  32  registered ALU result (forwarding source)
pc4_M, imm_extended_M  out  32 each  registered pass-through
rd_M  out  5  registered destination
read_data_M  out  32  extended load data
misaligned_M  out  1  current access is misaligned

Behaviour:
- EX/MEM register updates on rising clk. Priority: rst_n > FlushM > StallM > load.
- Reset and flush both clear every registered field to 0. Controls = 0 makes a bubble.
- StallM holds all fields.
- Reset/flush asserted together with StallM: the clear wins.
- Word index = alu_rsl_M[ADDR_BITS+1:2]. Higher address bits are ignored, so addresses wrap modulo RAM size.
- Byte offset = alu_rsl_M[1:0].
- Alignment rules:
  - mode[1:0]=00 (byte): always aligned.
  - mode[1:0]=01 (half): offset[0] must be 0.
  - mode[1:0]=10 (word): offset must be 00.
  - mode[1:0]=11: reserved, treated as misaligned.
- misaligned_M = (memRead_M | memWrite_M) & alignment violation. It is combinational from the registered fields.
- Store:
  - Executes at the rising edge when memWrite_M=1, misaligned_M=0 and rst_n=0.
  - Byte lanes enabled per size/offset. Data is write_data_M replicated into the selected lanes.
  - SB/SH/SW = mode 000/001/010.
  - Unselected lanes are unchanged.
  - While StallM=1 the same store repeats each cycle. This is idempotent and permitted.
- Load:
  - read_data_M is combinational from the RAM word and the registered fields, with zero added latency inside the MEM cycle.
  - LB sign-extends the selected byte. LBU zero-extends it.
  - LH sign-extends the selected half. LHU zero-extends it.
  - LW returns the full word.
  - Mode encodings: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - read_data_M = 0 when memRead_M=0 or misaligned_M=1.
- Read-during-write: a load never coincides with a store in the same cycle. When the RAM is read in the cycle a store writes, read_data_M shows the pre-write contents; the new data is visible from the next cycle.
- RAM contents are not reset. Reset does not disturb stored data.
- A misaligned store performs no write. A misaligned load returns 0. Both assert misaligned_M for that cycle only.

Test Plan:
1. Reset/pass-through: assert rst_n 2 cycles -> all outputs 0. Release, drive alu_rsl_E=0x1234, rd_E=7, regWrite_E=1, write_back_E=00 -> next cycle alu_rsl_M=0x1234, rd_M=7, regWrite_M=1.
2. Word store/load: SW 0xDEADBEEF @0x10, then LW @0x10 -> read_data_M=0xDEADBEEF. LW @0x10+(4<<ADDR_BITS) returns the same value (wrap).
3. Sub-word: SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80. LBU -> 0x00000080. SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001. LW @0x20 -> 0x8001_80xx with byte0 unchanged.
4. Misaligned: LW @0x13 -> misaligned_M=1, read_data_M=0. SH 0xAAAA @0x11 -> misaligned_M=1 and a following LW @0x10 shows the word unchanged.
5. Stall/flush: load a store, hold StallM=1 for 3 cycles -> outputs stable and RAM written once-equivalent. Assert FlushM with StallM=1 -> next cycle memWrite_M=regWrite_M=0.
6. Reset mid-operation: SW 0x55 @0x40, then assert rst_n on the same cycle as the next SW 0x66 @0x40 enters -> the second store never executes. LW @0x40 after release returns 0x55.
